// File: rtl/stack_unit_pkg.sv
// Shared stack sizing defaults and operation decode for the operand stack.
// Controller and datapath size their stack ports from the same values.
package stack_unit_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_TOP,
        OP_REPLACE,
        OP_PUSH_TOP
    } stack_op_e;

    // pop dominates top; push+pop is a replace of the top entry
    function automatic stack_op_e decode_op(input logic push, input logic pop, input logic top);
        stack_op_e op;
        if (push && pop)      op = OP_REPLACE;
        else if (pop)         op = OP_POP;
        else if (push && top) op = OP_PUSH_TOP;
        else if (push)        op = OP_PUSH;
        else if (top)         op = OP_TOP;
        else                  op = OP_IDLE;
        return op;
    endfunction

endpackage

// File: rtl/stack_unit_ram.sv
// Stack register file: one synchronous write port, one asynchronous read port.
// No reset; contents are only observed through valid stack entries.
module stack_unit_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack: push/pop/top strobes, registered top-of-stack output, sticky error flags.
// Latency: one cycle per operation, results visible after the edge.
// Backpressure: none; a push when full or a pop when empty is refused and flagged.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             top,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [AW:0]      sp, sp_nxt;
    logic [WIDTH-1:0] d_out_nxt, rdata, top_val;
    logic             ovf_nxt, unf_nxt, we;
    logic [AW-1:0]    raddr, waddr;
    stack_op_e        op;

    assign count   = sp;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign raddr   = sp[AW-1:0] - AW'(1);
    assign top_val = empty ? '0 : rdata;
    assign op      = decode_op(push, pop, top);

    always_comb begin
        sp_nxt    = sp;
        d_out_nxt = d_out;
        ovf_nxt   = overflow;
        unf_nxt   = underflow;
        we        = 1'b0;
        waddr     = sp[AW-1:0];
        case (op)
            OP_POP: begin
                if (empty) begin
                    unf_nxt = 1'b1;
                end else begin
                    d_out_nxt = rdata;
                    sp_nxt    = sp - (AW+1)'(1);
                end
            end
            OP_TOP: d_out_nxt = top_val;
            OP_REPLACE: begin
                // on an empty stack this degrades to a plain push, which cannot overflow
                we = 1'b1;
                if (empty) begin
                    sp_nxt = sp + (AW+1)'(1);
                end else begin
                    d_out_nxt = rdata;
                    waddr     = raddr;
                end
            end
            OP_PUSH, OP_PUSH_TOP: begin
                if (op == OP_PUSH_TOP) d_out_nxt = top_val;
                if (full) begin
                    ovf_nxt = 1'b1;
                end else begin
                    we     = 1'b1;
                    sp_nxt = sp + (AW+1)'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp        <= '0;
            d_out     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_nxt;
            d_out     <= d_out_nxt;
            overflow  <= ovf_nxt;
            underflow <= unf_nxt;
        end
    end

    // a write coinciding with reset is dropped
    stack_unit_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we && !rst),
        .waddr (waddr),
        .wdata (d_in),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0, pop = 1'b0, top = 1'b0;
    logic [WIDTH-1:0] d_in = '0;
    logic [WIDTH-1:0] d_out;
    logic [AW:0]      count;
    logic             empty, full, overflow, underflow;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_ovf = 1'b0, m_unf = 1'b0;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .top       (top),
        .d_in      (d_in),
        .d_out     (d_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_op(input logic p, input logic o, input logic t, input logic [WIDTH-1:0] d);
        if (o) begin
            if (p) begin
                if (q.size() > 0) begin
                    m_dout = q[q.size()-1];
                    q[q.size()-1] = d;
                end else begin
                    q.push_back(d);
                end
            end else if (q.size() > 0) begin
                m_dout = q.pop_back();
            end else begin
                m_unf = 1'b1;
            end
        end else begin
            if (t) m_dout = (q.size() > 0) ? q[q.size()-1] : '0;
            if (p) begin
                if (q.size() < DEPTH) q.push_back(d);
                else                  m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_dout"},  32'(d_out),     32'(m_dout));
        check({tag, "_count"}, 32'(count),     32'(q.size()));
        check({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
        check({tag, "_unf"},   32'(underflow), 32'(m_unf));
    endtask

    // called at a negedge; drives for one cycle, checks at the following negedge
    task automatic step(input string tag, input logic p, input logic o, input logic t,
                        input logic [WIDTH-1:0] d);
        push = p; pop = o; top = t; d_in = d;
        @(posedge clk);
        model_op(p, o, t, d);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; top = 1'b0;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // occupancy flags must always agree with count
    always @(negedge clk) begin
        if (!rst) begin
            check("empty_cons", 32'(empty), 32'(count == 0));
            check("full_cons",  32'(full),  32'(count == DEPTH));
        end
    end

    initial begin
        @(negedge clk);
        do_reset();

        // 1: reset then idle
        repeat (3) step("idle", 1'b0, 1'b0, 1'b0, '0);
        check("t1_count", 32'(count), 0);
        check("t1_empty", 32'(empty), 1);
        check("t1_full",  32'(full), 0);
        check("t1_dout",  32'(d_out), 0);

        // 2: push three, top, pop three
        step("t2_push", 1'b1, 1'b0, 1'b0, 8'h11);
        step("t2_push", 1'b1, 1'b0, 1'b0, 8'h22);
        step("t2_push", 1'b1, 1'b0, 1'b0, 8'h33);
        step("t2_top",  1'b0, 1'b0, 1'b1, '0);
        check("t2_top_val", 32'(d_out), 32'h33);
        check("t2_top_cnt", 32'(count), 3);
        step("t2_pop", 1'b0, 1'b1, 1'b0, '0);
        check("t2_pop0", 32'(d_out), 32'h33);
        step("t2_pop", 1'b0, 1'b1, 1'b0, '0);
        check("t2_pop1", 32'(d_out), 32'h22);
        step("t2_pop", 1'b0, 1'b1, 1'b0, '0);
        check("t2_pop2", 32'(d_out), 32'h11);
        check("t2_empty", 32'(empty), 1);

        // 3: fill, overflow, pop
        for (int i = 0; i < DEPTH; i++) step("t3_fill", 1'b1, 1'b0, 1'b0, 8'(i));
        check("t3_full", 32'(full), 1);
        step("t3_ovf", 1'b1, 1'b0, 1'b0, 8'hAA);
        check("t3_ovf_flag", 32'(overflow), 1);
        check("t3_ovf_cnt",  32'(count), 16);
        step("t3_pop", 1'b0, 1'b1, 1'b0, '0);
        check("t3_pop_val", 32'(d_out), 32'h0F);
        for (int i = 0; i < DEPTH - 1; i++) step("t3_drain", 1'b0, 1'b1, 1'b0, '0);

        // 4: underflow and top on empty
        step("t4_unf", 1'b0, 1'b1, 1'b0, '0);
        check("t4_unf_flag", 32'(underflow), 1);
        check("t4_unf_dout", 32'(d_out), 32'h00);
        check("t4_unf_cnt",  32'(count), 0);
        step("t4_top", 1'b0, 1'b0, 1'b1, '0);
        check("t4_top_val", 32'(d_out), 0);

        // 5: replace top
        step("t5_push", 1'b1, 1'b0, 1'b0, 8'h05);
        step("t5_push", 1'b1, 1'b0, 1'b0, 8'h07);
        step("t5_repl", 1'b1, 1'b1, 1'b0, 8'h09);
        check("t5_repl_val", 32'(d_out), 32'h07);
        check("t5_repl_cnt", 32'(count), 2);
        step("t5_pop", 1'b0, 1'b1, 1'b0, '0);
        check("t5_pop_val", 32'(d_out), 32'h09);

        // random traffic, alternating push-heavy and pop-heavy phases
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic p, o, t;
            int   bias;
            bias = ((i / 150) % 2 == 0) ? 70 : 30;
            p = ($urandom_range(0, 99) < bias);
            o = ($urandom_range(0, 99) < (100 - bias));
            t = ($urandom_range(0, 3) == 0);
            step("rand", p, o, t, 8'($urandom));
        end

        // 6: asynchronous reset in the middle of a push
        step("t6_push", 1'b1, 1'b0, 1'b0, 8'h44);
        push = 1'b1; d_in = 8'h55;
        #2 rst = 1'b1;
        #1;
        check("t6_async_cnt",  32'(count), 0);
        check("t6_async_dout", 32'(d_out), 0);
        check("t6_async_empty", 32'(empty), 1);
        model_reset();
        @(negedge clk);
        push = 1'b0;
        rst  = 1'b0;
        step("t6_top", 1'b0, 1'b0, 1'b1, '0);
        check("t6_top_val", 32'(d_out), 0);
        check("t6_top_cnt", 32'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
